pc11_feeder: RTL
================

# pc11_feeder

Sequencer that drives the paper tape controller's ARM-side register port on the fabric's behalf. It services reader start requests from a host-filled byte FIFO and drains punched bytes into a host-read FIFO. The PDP-11 therefore sees a live reader and punch without per-character ARM software involvement. It sits between the ARM/AXI glue and the tape controller's `armwrite/armraddr/armwaddr/armwdata/armrdata` port.

## Interface

- `DEPTH_LOG2`, 4: log2 of each FIFO depth (16 bytes).
- `CLOCK`  in  1: fabric clock.
- `RESET`  in  1: synchronous, active-high.
- `enable`  in  1: polling allowed; when low, the in-flight op completes, then the block idles.
- `rd_push`  in  1: push `rd_wdata` into the reader FIFO.
- `rd_wdata`  in  8: reader byte.
- `rd_eof`  in  1: level; tape exhausted once the reader FIFO is empty.
- `rd_full`  out  1: reader FIFO full.
- `rd_count`  out  DEPTH_LOG2+1: reader FIFO occupancy.
- `pn_pop`  in  1: pop the punch FIFO head.
- `pn_rdata`  out  8: punch FIFO head (first-word-fall-through).
- `pn_empty`  out  1: punch FIFO empty.
- `pace_cycles`  in  16: per-character reader delay (see Configuration).
- `pc_armwrite`  out  1: write strobe to the tape controller.
- `pc_armraddr`  out  2: read select to the tape controller.
- `pc_armwaddr`  out  2: write select to the tape controller.
- `pc_armwdata`  out  32: write data to the tape controller.
- `pc_armrdata`  in  32: combinational read data from the tape controller.

## Operation

- **Controller register words:**
  - Word 1 = {rbuf, rcsr}: busy = bit 11, done = bit 7.
  - Word 2 = {xbuf, xcsr}: done = bit 7; the punched byte is in bits [23:16].
- **FSM states:** IDLE, RSEL, RCHK, RWR, XSEL, XCHK, XWR.
- **Service order:** reader and punch are served round-robin. Each pass is IDLE → RSEL → RCHK → (RWR) → XSEL → XCHK → (XWR) → IDLE.
- **IDLE:** moves to RSEL when `enable` = 1; otherwise stays.
- **RSEL:** `pc_armraddr` = 1.
- **RCHK:** samples `pc_armrdata`. Reader is serviceable when busy = 1, done = 0, and pace is clear.
  - Serviceable and FIFO non-empty → RWR with data {8'h00, head, 16'h0080}. This loads rbuf, clears busy, and sets done. The FIFO pops.
  - Serviceable, FIFO empty, and `rd_eof` = 1 → RWR with 32'h00008000. This sets error and clears busy.
  - Otherwise → XSEL.
- **RWR:** `pc_armwrite` = 1, `pc_armwaddr` = 1; then → XSEL.
- **XSEL:** `pc_armraddr` = 2.
- **XCHK:** if done = 0 and the punch FIFO is not full, push `pc_armrdata[23:16]` → XWR with data 32'h00000080 (sets done). Otherwise → IDLE. A full punch FIFO leaves done = 0, so the PDP stalls.
- **XWR:** `pc_armwrite` = 1, `pc_armwaddr` = 2; then → IDLE.
- **Reader FIFO boundaries:** push when full is ignored. Simultaneous push and pop are both honoured, and the count is unchanged.
- **Punch FIFO boundaries:** pop when empty is ignored. A host pop and an XCHK push in the same cycle are both honoured.
- **Race window:** a PDP CSR write landing between RCHK/XCHK and the following write is overwritten for the bits the write touches. This is accepted.

## Timing

- **Reset values:** `pc_armwrite` = 0, `pc_armraddr` = 0, `pc_armwaddr` = 0, `pc_armwdata` = 0, FIFOs empty, `rd_full` = 0, `rd_count` = 0, `pn_empty` = 1, state IDLE, pace counter 0.
- **Outputs:** all registered. `pc_armwrite` is high for exactly one cycle per write.
- **Read sampling:** `pc_armrdata` is sampled in the cycle after the select is driven.
- **Pass length:** minimum 5 cycles (no writes), maximum 7 cycles. Reader latency from busy set to done set is at most 7 cycles plus pace.
- **FIFO status:** `rd_full`, `rd_count`, `pn_empty` and `pn_rdata` update the cycle after a push or pop.
- **Reset mid-operation:** RESET in any state returns the block to IDLE the next cycle. A pending write is dropped and FIFO contents are discarded.
- **enable low:** deassertion mid-pass finishes the current pass.

## Configuration

- **`PC11_FEEDER_PACE_EN` defined:**
  - A 16-bit down-counter loads `pace_cycles` on every RWR and decrements to 0.
  - RCHK treats the reader as not serviceable while the counter is non-zero. Punch service is unaffected.
  - `pace_cycles` = 0 gives no delay.
- **`PC11_FEEDER_PACE_EN` undefined:** no counter, `pace_cycles` is ignored, and the reader is serviced at the next pass.

## Test plan

- Push 8'o101 and 8'o102; model sets busy → exactly one write to word 1 with data 32'h00410080; after the second start, 32'h00420080; `rd_count` returns to 0.
- Reader FIFO empty, `rd_eof` = 1, busy set → single write of 32'h00008000; no FIFO pop.
- PDP writes xbuf = 8'o377 (done clears) → `pn_rdata` = 8'hFF, `pn_empty` = 0, write 32'h00000080 to word 2.
- Punch FIFO filled to 16 bytes, another punch pending → no word 2 write until `pn_pop`; then the byte is pushed within 7 cycles.
- With `PC11_FEEDER_PACE_EN` and `pace_cycles` = 100 → consecutive reader writes at least 100 cycles apart; punch is still serviced within 7 cycles.
- RESET asserted in RCHK with 3 bytes queued → next cycle IDLE, `rd_count` = 0, no `pc_armwrite` pulse.

Source files
------------

// File: rtl/pc11_feeder.sv
// pc11_feeder: sequencer that drives the paper tape controller's ARM-side register port.
// It feeds reader bytes from a host-filled FIFO and drains punched bytes into a host-read FIFO.
// Each pass services the reader, then the punch, through the controller's select/read/write port.
// Optional build macro PC11_FEEDER_PACE_EN adds a per-character reader delay counter.
module pc11_feeder #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic                  rd_push,
    input  logic [7:0]            rd_wdata,
    input  logic                  rd_eof,
    output logic                  rd_full,
    output logic [DEPTH_LOG2:0]   rd_count,
    input  logic                  pn_pop,
    output logic [7:0]            pn_rdata,
    output logic                  pn_empty,
    input  logic [15:0]           pace_cycles,
    output logic                  pc_armwrite,
    output logic [1:0]            pc_armraddr,
    output logic [1:0]            pc_armwaddr,
    output logic [31:0]           pc_armwdata,
    input  logic [31:0]           pc_armrdata
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] CountOne = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

    // Controller register word selects and field positions.
    localparam logic [1:0] WordReader = 2'd1;
    localparam logic [1:0] WordPunch  = 2'd2;
    localparam int unsigned BitBusy = 11;
    localparam int unsigned BitDone = 7;

    typedef enum logic [2:0] {
        StIdle,
        StRsel,
        StRchk,
        StRwr,
        StXsel,
        StXchk,
        StXwr
    } state_e;

    state_e state_q, state_d;

    // Reader FIFO (host -> controller)
    logic [7:0]            rd_mem_q [Depth];
    logic [DEPTH_LOG2-1:0] rd_wptr_q, rd_rptr_q;
    logic [DEPTH_LOG2:0]   rd_count_q;
    logic                  rd_do_push, rd_do_pop;
    logic [7:0]            rd_head;

    // Punch FIFO (controller -> host)
    logic [7:0]            pn_mem_q [Depth];
    logic [DEPTH_LOG2-1:0] pn_wptr_q, pn_rptr_q;
    logic [DEPTH_LOG2:0]   pn_count_q;
    logic                  pn_do_push, pn_do_pop;
    logic                  pn_full;

    // Registered controller-port outputs
    logic        armwrite_q, armwrite_d;
    logic [1:0]  armraddr_q, armraddr_d;
    logic [1:0]  armwaddr_q, armwaddr_d;
    logic [31:0] armwdata_q, armwdata_d;

    logic pace_clear;
    logic rd_serviceable;

    // Bits of the read word that the sequencer never looks at.
    logic unused_rdata;
    assign unused_rdata = ^{pc_armrdata[31:24], pc_armrdata[15:12], pc_armrdata[10:8],
                            pc_armrdata[6:0]};

`ifdef PC11_FEEDER_PACE_EN
    logic [15:0] pace_q;

    // Pace counter: reload on every reader write, then count down to zero.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pace_q <= 16'd0;
        end else if (state_q == StRwr) begin
            pace_q <= pace_cycles;
        end else if (pace_q != 16'd0) begin
            pace_q <= pace_q - 16'd1;
        end
    end

    assign pace_clear = (pace_q == 16'd0);
`else
    logic unused_pace;
    assign unused_pace = ^pace_cycles;
    assign pace_clear  = 1'b1;
`endif

    // ---------------------------------------------------------------------------------------
    // Reader FIFO
    // ---------------------------------------------------------------------------------------
    assign rd_do_push = rd_push && (rd_count_q != DepthCount);
    assign rd_head    = rd_mem_q[rd_rptr_q];
    assign rd_full    = (rd_count_q == DepthCount);
    assign rd_count   = rd_count_q;

    // Reader FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge CLOCK) begin
        if (rd_do_push) begin
            rd_mem_q[rd_wptr_q] <= rd_wdata;
        end
    end

    // Reader FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rd_wptr_q  <= '0;
            rd_rptr_q  <= '0;
            rd_count_q <= '0;
        end else begin
            if (rd_do_push) begin
                rd_wptr_q <= rd_wptr_q + PtrOne;
            end
            if (rd_do_pop) begin
                rd_rptr_q <= rd_rptr_q + PtrOne;
            end
            case ({rd_do_push, rd_do_pop})
                2'b10:   rd_count_q <= rd_count_q + CountOne;
                2'b01:   rd_count_q <= rd_count_q - CountOne;
                default: rd_count_q <= rd_count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Punch FIFO
    // ---------------------------------------------------------------------------------------
    assign pn_do_pop = pn_pop && (pn_count_q != '0);
    assign pn_full   = (pn_count_q == DepthCount);
    assign pn_empty  = (pn_count_q == '0);
    assign pn_rdata  = pn_mem_q[pn_rptr_q];

    // Punch FIFO storage, written straight from the xbuf field during XCHK.
    always_ff @(posedge CLOCK) begin
        if (pn_do_push) begin
            pn_mem_q[pn_wptr_q] <= pc_armrdata[23:16];
        end
    end

    // Punch FIFO pointers and occupancy; a host pop and an XCHK push may coincide.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pn_wptr_q  <= '0;
            pn_rptr_q  <= '0;
            pn_count_q <= '0;
        end else begin
            if (pn_do_push) begin
                pn_wptr_q <= pn_wptr_q + PtrOne;
            end
            if (pn_do_pop) begin
                pn_rptr_q <= pn_rptr_q + PtrOne;
            end
            case ({pn_do_push, pn_do_pop})
                2'b10:   pn_count_q <= pn_count_q + CountOne;
                2'b01:   pn_count_q <= pn_count_q - CountOne;
                default: pn_count_q <= pn_count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------------------------
    assign rd_serviceable = pc_armrdata[BitBusy] && !pc_armrdata[BitDone] && pace_clear;

    // State register and registered controller-port outputs; reset drops any pending write.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= StIdle;
            armwrite_q <= 1'b0;
            armraddr_q <= 2'd0;
            armwaddr_q <= 2'd0;
            armwdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            armwrite_q <= armwrite_d;
            armraddr_q <= armraddr_d;
            armwaddr_q <= armwaddr_d;
            armwdata_q <= armwdata_d;
        end
    end

    // Next state, FIFO strobes and next output values (outputs follow the next state).
    always_comb begin
        state_d    = state_q;
        rd_do_pop  = 1'b0;
        pn_do_push = 1'b0;
        armwdata_d = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRsel;
                end
            end
            StRsel: state_d = StRchk;
            StRchk: begin
                state_d = StXsel;
                if (rd_serviceable) begin
                    if (rd_count_q != '0) begin
                        // Load rbuf, clear busy, set done.
                        state_d    = StRwr;
                        rd_do_pop  = 1'b1;
                        armwdata_d = {8'h00, rd_head, 16'h0080};
                    end else if (rd_eof) begin
                        // Tape exhausted: set error, clear busy.
                        state_d    = StRwr;
                        armwdata_d = 32'h0000_8000;
                    end
                end
            end
            StRwr: state_d = StXsel;
            StXsel: state_d = StXchk;
            StXchk: begin
                state_d = StIdle;
                // A full punch FIFO leaves done clear, which stalls the PDP-11.
                if (!pc_armrdata[BitDone] && !pn_full) begin
                    state_d    = StXwr;
                    pn_do_push = 1'b1;
                    armwdata_d = 32'h0000_0080;
                end
            end
            StXwr: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        armwrite_d = (state_d == StRwr) || (state_d == StXwr);

        unique case (state_d)
            StRwr:   armwaddr_d = WordReader;
            StXwr:   armwaddr_d = WordPunch;
            default: armwaddr_d = 2'd0;
        endcase

        // Hold the select through the check so the sampled read data is stable.
        unique case (state_d)
            StRsel, StRchk, StRwr: armraddr_d = WordReader;
            StXsel, StXchk, StXwr: armraddr_d = WordPunch;
            default:               armraddr_d = 2'd0;
        endcase
    end

    assign pc_armwrite = armwrite_q;
    assign pc_armraddr = armraddr_q;
    assign pc_armwaddr = armwaddr_q;
    assign pc_armwdata = armwdata_q;

endmodule
